// File: rtl/array6_ctrl_pkg.sv
// rtl/array6_ctrl_pkg.sv - shared constants and enums for the array_6 port controller
package array6_ctrl_pkg;

  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 22;
  localparam int MASK_SEG = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

endpackage

// File: rtl/array6_resp_fifo.sv
// rtl/array6_resp_fifo.sv - 2-entry valid/ready read-response FIFO with occupancy count
module array6_resp_fifo
  import array6_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  // A pop frees the head slot this cycle, so a push into a full FIFO is legal
  // when paired with a pop.
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

  // Storage, pointers and count; head data only changes on a pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= i_push_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop_ok) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/array6_port_ctrl.sv
// rtl/array6_port_ctrl.sv - zero-fill, round-robin read/write arbitration onto the array_6 RW port
module array6_port_ctrl
  import array6_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  output logic                init_done,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_req_addr,
  output logic                rd_resp_valid,
  input  logic                rd_resp_ready,
  output logic [DATA_W-1:0]   rd_resp_data,
  input  logic                wr_req_valid,
  output logic                wr_req_ready,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [MASK_SEG-1:0] wr_req_mask,
  input  logic [DATA_W-1:0]   wr_req_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [MASK_SEG-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic [ADDR_W-1:0] w_init_cnt_nxt;
  logic              r_rd_inflight;
  grant_e            r_rr_last;
  grant_e            w_grant;
  logic [1:0]        w_fifo_count;
  logic              w_resp_valid;
  logic [DATA_W-1:0] w_resp_data;
  logic              w_resp_fire;
  logic [2:0]        w_outstanding;
  logic              w_rd_elig;
  logic              w_wr_elig;

  // Reads already accepted but not yet consumed; a read is only taken when its
  // response is guaranteed a FIFO slot, so the FIFO can never overflow.
  assign w_resp_fire   = w_resp_valid && rd_resp_ready;
  assign w_outstanding = {2'b00, r_rd_inflight} + {1'b0, w_fifo_count}
                         - {2'b00, w_resp_fire};
  assign w_rd_elig     = rd_req_valid && (w_outstanding < 3'd2);
  assign w_wr_elig     = wr_req_valid;

  // FSM state and zero-fill counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Next state: sweep every entry once, then stay in RUN until reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    if (r_state == INIT) begin
      w_init_cnt_nxt = r_init_cnt + 1'b1;
      if (r_init_cnt == ADDR_W'(DEPTH - 1)) begin
        w_state_nxt = RUN;
      end
    end
  end

  // Round-robin arbiter: a lone eligible requester wins, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    w_grant = GNT_NONE;
    if (r_state == RUN) begin
      if (w_rd_elig && w_wr_elig) begin
        w_grant = (r_rr_last == GNT_RD) ? GNT_WR : GNT_RD;
      end else if (w_wr_elig) begin
        w_grant = GNT_WR;
      end else if (w_rd_elig) begin
        w_grant = GNT_RD;
      end
    end
  end

  // Round-robin history and the one-cycle read-in-flight marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_last     <= GNT_RD;
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= (w_grant == GNT_RD);
      if (w_grant != GNT_NONE) begin
        r_rr_last <= w_grant;
      end
    end
  end

  // Macro port drive; everything idles at zero while reset is held so the
  // array is never touched before the sweep starts.
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (r_state == INIT) begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_wmask = '1;
        mem_addr  = r_init_cnt;
      end else begin
        case (w_grant)
          GNT_WR: begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = wr_req_addr;
            mem_wmask = wr_req_mask;
            mem_wdata = wr_req_data;
          end
          GNT_RD: begin
            mem_en   = 1'b1;
            mem_addr = rd_req_addr;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rd_req_ready = (w_grant == GNT_RD);
  assign wr_req_ready = (w_grant == GNT_WR);
  assign init_done    = (r_state == RUN);

  // Read data appears on the macro the cycle after the enable and is captured
  // into the FIFO at the end of that cycle.
  array6_resp_fifo u_resp_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_rd_inflight),
    .i_push_data (mem_rdata),
    .i_pop       (rd_resp_ready),
    .o_valid     (w_resp_valid),
    .o_data      (w_resp_data),
    .o_count     (w_fifo_count)
  );

  assign rd_resp_valid = w_resp_valid;
  assign rd_resp_data  = w_resp_data;

endmodule
